// File: rtl/arm_hazard_forward_unit.sv
// Hazard/forwarding controller for the 5-stage ARM pipeline (F/D/E/M/W).
// Optional perf counters: define HAZARD_PERF_COUNT_EN.
module arm_hazard_forward_unit #(
  parameter int RegAddrWidth = 4,
  parameter int CountWidth   = 16
) (
  input  logic                    i_CLK,
  input  logic                    i_NRESET,
  input  logic [RegAddrWidth-1:0] i_RA1_D,
  input  logic [RegAddrWidth-1:0] i_RA2_D,
  input  logic [RegAddrWidth-1:0] i_Rd_D,
  input  logic                    i_RegWrite_D,
  input  logic                    i_MemToReg_D,
  input  logic                    i_PCSrc_D,
  input  logic                    i_BranchTaken_E,
  output logic [1:0]              o_ForwardA_E,
  output logic [1:0]              o_ForwardB_E,
  output logic                    o_StallF,
  output logic                    o_StallD,
  output logic                    o_FlushD,
  output logic                    o_FlushE,
  output logic [CountWidth-1:0]   o_StallCount,
  output logic [CountWidth-1:0]   o_FlushCount
);

  localparam logic [RegAddrWidth-1:0] RegPc = '1;

  logic [RegAddrWidth-1:0] ra1_e_q, ra1_e_d;
  logic [RegAddrWidth-1:0] ra2_e_q, ra2_e_d;
  logic [RegAddrWidth-1:0] rd_e_q, rd_e_d;
  logic [RegAddrWidth-1:0] rd_m_q, rd_m_d;
  logic [RegAddrWidth-1:0] rd_w_q, rd_w_d;
  logic regwr_e_q, regwr_e_d;
  logic regwr_m_q, regwr_m_d;
  logic regwr_w_q, regwr_w_d;
  logic memrd_e_q, memrd_e_d;
  logic pcsrc_e_q, pcsrc_e_d;
  logic pcsrc_m_q, pcsrc_m_d;
  logic pcsrc_w_q, pcsrc_w_d;

  logic ld_stall;
  logic pc_wr_pend;
  logic flush_e;

  always_comb begin
    o_ForwardA_E = 2'b00;
    if (ra1_e_q != RegPc) begin
      if (regwr_m_q && rd_m_q == ra1_e_q) begin
        o_ForwardA_E = 2'b10;
      end else if (regwr_w_q && rd_w_q == ra1_e_q) begin
        o_ForwardA_E = 2'b01;
      end
    end
  end

  always_comb begin
    o_ForwardB_E = 2'b00;
    if (ra2_e_q != RegPc) begin
      if (regwr_m_q && rd_m_q == ra2_e_q) begin
        o_ForwardB_E = 2'b10;
      end else if (regwr_w_q && rd_w_q == ra2_e_q) begin
        o_ForwardB_E = 2'b01;
      end
    end
  end

  // A taken branch squashes the dependent instr, so no load-use bubble.
  always_comb begin
    ld_stall = memrd_e_q && regwr_e_q && (rd_e_q != RegPc)
            && ((rd_e_q == i_RA1_D) || (rd_e_q == i_RA2_D))
            && !i_BranchTaken_E;
    pc_wr_pend = i_PCSrc_D | pcsrc_e_q | pcsrc_m_q;
    flush_e    = i_NRESET & (ld_stall | i_BranchTaken_E);
  end

  assign o_StallD = ld_stall;
  assign o_StallF = ld_stall | pc_wr_pend;
  assign o_FlushE = flush_e;
  assign o_FlushD = pc_wr_pend | pcsrc_w_q | i_BranchTaken_E;

  always_comb begin
    ra1_e_d   = flush_e ? '0   : i_RA1_D;
    ra2_e_d   = flush_e ? '0   : i_RA2_D;
    rd_e_d    = flush_e ? '0   : i_Rd_D;
    regwr_e_d = flush_e ? 1'b0 : i_RegWrite_D;
    memrd_e_d = flush_e ? 1'b0 : i_MemToReg_D;
    pcsrc_e_d = flush_e ? 1'b0 : i_PCSrc_D;
    rd_m_d    = rd_e_q;
    regwr_m_d = regwr_e_q;
    pcsrc_m_d = pcsrc_e_q;
    rd_w_d    = rd_m_q;
    regwr_w_d = regwr_m_q;
    pcsrc_w_d = pcsrc_m_q;
  end

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      ra1_e_q   <= '0;
      ra2_e_q   <= '0;
      rd_e_q    <= '0;
      rd_m_q    <= '0;
      rd_w_q    <= '0;
      regwr_e_q <= 1'b0;
      regwr_m_q <= 1'b0;
      regwr_w_q <= 1'b0;
      memrd_e_q <= 1'b0;
      pcsrc_e_q <= 1'b0;
      pcsrc_m_q <= 1'b0;
      pcsrc_w_q <= 1'b0;
    end else begin
      ra1_e_q   <= ra1_e_d;
      ra2_e_q   <= ra2_e_d;
      rd_e_q    <= rd_e_d;
      rd_m_q    <= rd_m_d;
      rd_w_q    <= rd_w_d;
      regwr_e_q <= regwr_e_d;
      regwr_m_q <= regwr_m_d;
      regwr_w_q <= regwr_w_d;
      memrd_e_q <= memrd_e_d;
      pcsrc_e_q <= pcsrc_e_d;
      pcsrc_m_q <= pcsrc_m_d;
      pcsrc_w_q <= pcsrc_w_d;
    end
  end

`ifdef HAZARD_PERF_COUNT_EN
  logic [CountWidth-1:0] stall_cnt_q, stall_cnt_d;
  logic [CountWidth-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ld_stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (i_BranchTaken_E && flush_cnt_q != '1) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_StallCount = stall_cnt_q;
  assign o_FlushCount = flush_cnt_q;
`else
  assign o_StallCount = '0;
  assign o_FlushCount = '0;
`endif

endmodule

// File: tb/tb_arm_hazard_forward_unit.sv
// Randomized + directed bench for arm_hazard_forward_unit
// against an instruction-history reference model.
module tb_arm_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ra1_d, ra2_d, rd_d;
  logic        rw_d, mtr_d, pcs_d, br_e;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [15:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arm_hazard_forward_unit #(
    .RegAddrWidth(4),
    .CountWidth(16)
  ) dut (
    .i_CLK(clk),
    .i_NRESET(rst_n),
    .i_RA1_D(ra1_d),
    .i_RA2_D(ra2_d),
    .i_Rd_D(rd_d),
    .i_RegWrite_D(rw_d),
    .i_MemToReg_D(mtr_d),
    .i_PCSrc_D(pcs_d),
    .i_BranchTaken_E(br_e),
    .o_ForwardA_E(fwd_a),
    .o_ForwardB_E(fwd_b),
    .o_StallF(stall_f),
    .o_StallD(stall_d),
    .o_FlushD(flush_d),
    .o_FlushE(flush_e),
    .o_StallCount(stall_cnt),
    .o_FlushCount(flush_cnt)
  );

  typedef struct {
    int ra1;
    int ra2;
    int rd;
    bit rw;
    bit mtr;
    bit pcs;
  } ins_t;

  // hist[0]=instr in E, hist[1]=M, hist[2]=W
  ins_t hist[3];
  int   m_stall_cnt;
  int   m_flush_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_fwd(input int ra);
    if (ra == 15) return 0;
    if (hist[1].rw && hist[1].rd == ra) return 2;
    if (hist[2].rw && hist[2].rd == ra) return 1;
    return 0;
  endfunction

  function automatic ins_t bubble();
    ins_t b;
    b.ra1 = 0; b.ra2 = 0; b.rd = 0;
    b.rw = 0; b.mtr = 0; b.pcs = 0;
    return b;
  endfunction

  task automatic step(input bit rn, input int a1, input int a2,
                      input int d, input bit w, input bit m,
                      input bit p, input bit b);
    bit   ld, pcw, xf, xfd, xsf;
    ins_t nw;
    @(negedge clk);
    rst_n = rn;
    ra1_d = 4'(a1); ra2_d = 4'(a2); rd_d = 4'(d);
    rw_d = w; mtr_d = m; pcs_d = p; br_e = b;
    #1;
    if (!rn) begin
      for (int i = 0; i < 3; i++) hist[i] = bubble();
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end
    ld  = hist[0].mtr && hist[0].rw && hist[0].rd != 15
       && (hist[0].rd == a1 || hist[0].rd == a2) && !b;
    pcw = p || hist[0].pcs || hist[1].pcs;
    xf  = rn && (ld || b);
    xsf = ld || pcw;
    xfd = pcw || hist[2].pcs || b;
    chk("fwdA", int'(fwd_a), ref_fwd(hist[0].ra1));
    chk("fwdB", int'(fwd_b), ref_fwd(hist[0].ra2));
    chk("stallF", int'(stall_f), int'(xsf));
    chk("stallD", int'(stall_d), int'(ld));
    chk("flushD", int'(flush_d), int'(xfd));
    chk("flushE", int'(flush_e), int'(xf));
`ifdef HAZARD_PERF_COUNT_EN
    chk("stallCnt", int'(stall_cnt), m_stall_cnt);
    chk("flushCnt", int'(flush_cnt), m_flush_cnt);
`else
    chk("stallCnt", int'(stall_cnt), 0);
    chk("flushCnt", int'(flush_cnt), 0);
`endif
    if (rn) begin
      if (xf) nw = bubble();
      else begin
        nw.ra1 = a1; nw.ra2 = a2; nw.rd = d;
        nw.rw = w; nw.mtr = m; nw.pcs = p;
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = nw;
      if (ld && m_stall_cnt < 65535) m_stall_cnt++;
      if (b && m_flush_cnt < 65535) m_flush_cnt++;
    end
  endtask

  task automatic nop();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    nop(); nop(); nop();
  endtask

  function automatic int rreg();
    int r = int'($urandom_range(0, 4));
    return (r == 4) ? 15 : r;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = bubble();
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    rst_n = 1'b0;
    ra1_d = '0; ra2_d = '0; rd_d = '0;
    rw_d = 0; mtr_d = 0; pcs_d = 0; br_e = 0;
    do_reset();

    // forward from M on SrcA only
    step(1, 0, 0, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    nop();
    chk("t1_fwdA", int'(fwd_a), 2);
    chk("t1_fwdB", int'(fwd_b), 0);

    // M beats W; then W only
    nop(); nop(); nop();
    step(1, 0, 0, 2, 1, 0, 0, 0);
    step(1, 0, 0, 2, 1, 0, 0, 0);
    step(1, 0, 2, 0, 0, 0, 0, 0);
    nop();
    chk("t2_mw", int'(fwd_b), 2);
    nop(); nop(); nop();
    step(1, 0, 0, 2, 1, 0, 0, 0);
    step(1, 0, 0, 2, 0, 0, 0, 0);
    step(1, 0, 2, 0, 0, 0, 0, 0);
    nop();
    chk("t2_w", int'(fwd_b), 1);

    // R15 source never forwards
    nop(); nop(); nop();
    step(1, 0, 0, 15, 1, 0, 0, 0);
    step(1, 15, 15, 0, 0, 0, 0, 0);
    nop();
    chk("pc_fwdA", int'(fwd_a), 0);

    // load-use: one bubble then forward from W
    nop(); nop(); nop();
    step(1, 0, 0, 3, 1, 1, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0, 0);
    chk("t3_stallF", int'(stall_f), 1);
    chk("t3_stallD", int'(stall_d), 1);
    chk("t3_flushE", int'(flush_e), 1);
    step(1, 3, 0, 0, 0, 0, 0, 0);
    chk("t3_nostall", int'(stall_d), 0);
    nop();
    chk("t3_fwdA", int'(fwd_a), 1);

    // load-use collides with taken branch
    nop(); nop(); nop();
    step(1, 0, 0, 1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 1);
    chk("t4_stallD", int'(stall_d), 0);
    chk("t4_flushD", int'(flush_d), 1);
    chk("t4_flushE", int'(flush_e), 1);

    // PC write: StallF 3 cycles, FlushD 4 cycles
    nop(); nop(); nop();
    step(1, 0, 0, 0, 0, 0, 1, 0);
    chk("t5_sf0", int'(stall_f), 1);
    chk("t5_fd0", int'(flush_d), 1);
    nop();
    chk("t5_sf1", int'(stall_f), 1);
    nop();
    chk("t5_sf2", int'(stall_f), 1);
    chk("t5_fd2", int'(flush_d), 1);
    nop();
    chk("t5_sf3", int'(stall_f), 0);
    chk("t5_fd3", int'(flush_d), 1);
    nop();
    chk("t5_fd4", int'(flush_d), 0);
    chk("t5_sf4", int'(stall_f), 0);

    // reset mid PC write and mid load-use
    step(1, 0, 0, 4, 1, 1, 1, 0);
    step(1, 4, 0, 0, 0, 0, 0, 0);
    step(0, 4, 0, 0, 0, 0, 0, 1);
    chk("t6_stallD", int'(stall_d), 0);
    chk("t6_flushE", int'(flush_e), 0);
    chk("t6_fwdA", int'(fwd_a), 0);
    chk("t6_stallF", int'(stall_f), 0);
    chk("t6_flushD", int'(flush_d), 1);
    step(1, 4, 0, 0, 0, 0, 0, 0);
    chk("t6_post_sf", int'(stall_f), 0);
    chk("t6_post_fd", int'(flush_d), 0);

`ifdef HAZARD_PERF_COUNT_EN
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 5, 1, 1, 0, 0);
      step(1, 5, 0, 0, 0, 0, 0, 0);
      step(1, 5, 0, 0, 0, 0, 0, 0);
    end
    nop();
    chk("t6_cnt3", int'(stall_cnt), 3);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_cnt0", int'(stall_cnt), 0);
`endif

    do_reset();
    for (int k = 0; k < 800; k++) begin
      step(($urandom_range(0, 59) != 0), rreg(), rreg(), rreg(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
